// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams.
// A grant is held for a whole packet. A requester that stalls mid-packet is released after GAP_TIMEOUT cycles.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int GAP_TIMEOUT = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          grant_active,
   output logic                          abort
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(GAP_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_WAIT = 2'd3;

   logic [1:0]                            state;
   logic [GW-1:0]                         last_grant;
   logic [GW-1:0]                         pick_id;
   logic                                  pick_found;
   logic [CW-1:0]                         gap_cnt;
   logic [CW-1:0]                         gap_nxt;
   logic                                  last_q;
   logic                                  cur_valid;
   logic                                  xfer;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_bytes;

   assign req_bytes = req_data;
   assign cur_valid = req_valid[grant_id];
   assign xfer      = (state == S_SEND) && !tx_busy && cur_valid;
   assign gap_nxt   = (gap_cnt == CW'(GAP_TIMEOUT)) ? gap_cnt : gap_cnt + 1'b1;

   always_comb begin
      req_ready = '0;
      if (state == S_SEND && !tx_busy) req_ready[grant_id] = 1'b1;
   end

   // Scan starts one past the previous owner so every requester gets a turn.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = last_grant;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!pick_found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
            pick_found = 1'b1;
            pick_id    = GW'((int'(last_grant) + k) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         last_grant   <= GW'(NUM_REQ - 1);
         grant_id     <= '0;
         grant_active <= 1'b0;
         gap_cnt      <= '0;
         last_q       <= 1'b0;
         tx_start     <= 1'b0;
         tx_data      <= '0;
         abort        <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         abort    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  grant_id     <= pick_id;
                  grant_active <= 1'b1;
                  gap_cnt      <= '0;
                  state        <= S_SEND;
               end
            end
            S_SEND: begin
               if (xfer) begin
                  tx_data  <= req_bytes[grant_id];
                  tx_start <= 1'b1;
                  last_q   <= req_last[grant_id];
                  gap_cnt  <= '0;
                  state    <= S_HOLD;
               end else if (!cur_valid) begin
                  gap_cnt <= gap_nxt;
                  if (gap_nxt == CW'(GAP_TIMEOUT)) begin
                     abort        <= 1'b1;
                     grant_active <= 1'b0;
                     last_grant   <= grant_id;
                     state        <= S_IDLE;
                  end
               end
            end
            // One dead cycle so the transmitter has time to raise tx_busy.
            S_HOLD: state <= S_WAIT;
            S_WAIT: begin
               if (!tx_busy) begin
                  if (last_q) begin
                     grant_active <= 1'b0;
                     last_grant   <= grant_id;
                     state        <= S_IDLE;
                  end else begin
                     gap_cnt <= '0;
                     state   <= S_SEND;
                  end
               end
            end
            default: begin
               grant_active <= 1'b0;
               state        <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ byte-stream requesters. It sits between the bus-side clients (register bridge, debug port, status reporter) and the transmitter. A grant is locked for a whole packet (until the byte flagged last), so packets never interleave on the serial line. A gap timeout releases a requester that stalls mid-packet.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_WIDTH, 8: byte width
- GAP_TIMEOUT, 1024: cycles a granted requester may leave req_valid low mid-packet before abort, ≥1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  byte is last of packet; sampled with the byte
- req_ready  out  NUM_REQ  byte accepted when valid&ready at a rising edge; combinational, one-hot or zero
- tx_start  out  1  one-cycle pulse to the transmitter
- tx_data  out  DATA_WIDTH  byte for the transmitter; valid while tx_start=1, held until the next start
- tx_busy  in  1  transmitter busy; must rise by the cycle after tx_start and fall when the stop bit ends
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester
- grant_active  out  1  a packet lock is held
- abort  out  1  one-cycle pulse when a gap timeout releases a grant

## Operation
- States: IDLE, SEND, HOLD, WAIT.
- IDLE: if any req_valid, select the first asserted index scanning from (last_grant+1) mod NUM_REQ upward with wrap. Latch grant_id, set grant_active, clear gap counter, go to SEND. Otherwise stay.
- SEND: req_ready[grant_id] = !tx_busy; all other req_ready are 0.
  - On transfer: register tx_data←byte, tx_start←1 for the next cycle, latch last←req_last[grant_id], go to HOLD.
  - Cycles in SEND without req_valid[grant_id] increment the gap counter. The counter clears on transfer.
  - When the counter reaches GAP_TIMEOUT: pulse abort, clear grant_active, last_grant←grant_id, go to IDLE.
- HOLD: exactly one cycle; tx_busy ignored, covering transmitter pickup latency. Go to WAIT.
- WAIT: when tx_busy=0:
  - if last: clear grant_active, last_grant←grant_id, go to IDLE;
  - else go to SEND with the gap counter cleared.
- Other requesters' valids are ignored while grant_active=1. No preemption.
- A requester dropping req_valid while not ready is legal; the arbiter never samples data without a handshake.
- Gap counter width is $clog2(GAP_TIMEOUT+1) and saturates at GAP_TIMEOUT.
- Unused or illegal state encodings go to IDLE.

## Timing
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_active=0, abort=0, state IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), gap counter 0.
- Reset asserted mid-packet: the next edge forces all of the above. The byte in flight in the transmitter is not tracked.
- Cycle numbering, first byte, with tx_busy=0 and req_valid rising in cycle 0 (IDLE):
  - cycle 1: SEND, req_ready high, transfer at the end of the cycle;
  - cycle 2: tx_start=1, state HOLD.
  - Latency from valid to tx_start is 2 cycles.
- Back-to-back bytes: next req_ready asserts in the cycle after tx_busy is sampled low in WAIT. Minimum spacing between tx_start pulses is (transmitter frame length + 3) cycles.
- Simultaneous requests: resolved in the single IDLE cycle; requests arriving later wait for release.
- Release to regrant: after last-byte completion or abort, IDLE takes one cycle. The new grant is visible 1 cycle after the IDLE decision.
- Abort fires on the edge where the counter reaches GAP_TIMEOUT: GAP_TIMEOUT idle SEND cycles, abort visible in the following cycle.
- tx_busy high in SEND: req_ready stays low and the gap counter still runs only if req_valid is low.

## Test plan
- Single packet: req 2 sends 0xA5,0x3C(last); transmitter model busy 160 cycles → tx_start ×2 with data 0xA5 then 0x3C, grant_id=2 throughout, grant_active drops after the second busy falls, no abort.
- Contention: reqs 0,1,3 valid together with 1-byte packets → service order 0,1,3. Then a repeat with all valid → order continues 0,1,3 from last_grant=3, i.e. fairness across wrap.
- Packet lock: req 1 sends a 3-byte packet while req 0 holds valid from byte 1 → req 0 gets no req_ready until req 1's last byte completes, then is granted.
- Gap timeout, GAP_TIMEOUT=8: req 0 sends a non-last byte then drops valid → abort pulses exactly 8 SEND cycles later, grant_active=0, next requester granted. A run with a 7-cycle gap gives no abort.
- Reset mid-packet: assert rst in WAIT of byte 2 → next cycle all outputs at reset values. A new request from req 1 after release is granted before req 2 (last_grant=NUM_REQ-1 restored).
- tx_busy held high: request valid in IDLE with busy=1 → grant taken, req_ready stays 0, no tx_start until busy falls; then transfer occurs the same cycle busy is low.
